isqrt_pipe: RTL and testbench

ISQRT_PIPE -- requirements
Module: isqrt_pipe

---
 rtl/isqrt_pipe.sv | 95 +++++++++
 tb/tb_isqrt_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/isqrt_pipe.sv
// ---------------------------------------------------------------------------
// isqrt_pipe
// Fully pipelined unsigned integer square root, y = floor(sqrt(x)).
// One root bit is resolved per stage by the restoring digit-by-digit
// (remainder) method, MSB first, so the pipeline is WIDTH/2 stages deep and
// accepts one operand every cycle with no backpressure.
//
// Ports
//   clk    : single clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset; clears the valid chain only
//   x_vld  : operand valid, sampled every cycle
//   x      : unsigned operand, WIDTH bits (WIDTH even, >= 4)
//   y_vld  : result valid, WIDTH/2 cycles after the operand was accepted
//   y      : unsigned root, WIDTH/2 bits, meaningful only while y_vld=1
// ---------------------------------------------------------------------------
module isqrt_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_vld,
  input  logic [WIDTH-1:0]   x,
  output logic               y_vld,
  output logic [WIDTH/2-1:0] y
);

  localparam int unsigned H = WIDTH / 2;  // root width and stage count
  localparam int unsigned R = H + 2;      // remainder width

  // Per-stage pipeline state. Only the valid chain is reset; the data
  // registers are don't-care until a valid operand passes through them.
  logic             vld_q  [H];
  logic [H-1:0]     root_q [H];  // root bits resolved so far, right-aligned
  logic [R-1:0]     rem_q  [H];  // partial remainder
  logic [WIDTH-1:0] opd_q  [H];  // unconsumed operand bits, left-aligned

  for (genvar k = 0; k < H; k++) begin : g_stage
    logic             in_vld;
    logic [H-1:0]     in_root;
    logic [R-1:0]     in_rem;
    logic [WIDTH-1:0] in_opd;

    logic [R-1:0]     cur;
    logic [R-1:0]     trial;
    logic             take;
    logic [H-1:0]     nxt_root;
    logic [R-1:0]     nxt_rem;
    logic [WIDTH-1:0] nxt_opd;

    if (k == 0) begin : g_src
      assign in_vld  = x_vld;
      assign in_root = '0;
      assign in_rem  = '0;
      assign in_opd  = x;
    end else begin : g_src
      assign in_vld  = vld_q[k-1];
      assign in_root = root_q[k-1];
      assign in_rem  = rem_q[k-1];
      assign in_opd  = opd_q[k-1];
    end

    // Bring down the next two operand bits and try subtracting 4*root+1.
    // The incoming remainder never exceeds 2*root < 2^H, so shifting it
    // left by two within R bits loses nothing.
    always_comb begin
      cur      = (in_rem << 2) | {{H{1'b0}}, in_opd[WIDTH-1 -: 2]};
      trial    = {in_root, 2'b01};
      take     = (cur >= trial);
      nxt_rem  = take ? (cur - trial) : cur;
      nxt_root = (in_root << 1) | {{(H-1){1'b0}}, take};
      nxt_opd  = in_opd << 2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
      end else begin
        vld_q[k] <= in_vld;
      end
    end

    // Data registers only move when a valid operand arrives.
    always_ff @(posedge clk) begin
      if (in_vld) begin
        root_q[k] <= nxt_root;
        rem_q[k]  <= nxt_rem;
        opd_q[k]  <= nxt_opd;
      end
    end
  end

  assign y_vld = vld_q[H-1];
  assign y     = root_q[H-1];

endmodule

// File: tb/tb_isqrt_pipe.sv
// ---------------------------------------------------------------------------
// tb_isqrt_pipe
// Directed bench for isqrt_pipe: a WIDTH=32 instance (corners, streaming,
// bubbles, power gating, mid-stream reset) and a WIDTH=8 instance
// (exhaustive back-to-back sweep). Every cycle the expected y_vld pattern is
// the driven x_vld pattern delayed by the pipeline depth.
// ---------------------------------------------------------------------------
module tb_isqrt_pipe;

  localparam int unsigned D32 = 16;
  localparam int unsigned D8  = 4;
  localparam int unsigned HN  = 4096;

  logic        clk;
  logic        rst_n;
  logic        x_vld32;
  logic [31:0] x32;
  logic        y_vld32;
  logic [15:0] y32;
  logic        x_vld8;
  logic [7:0]  x8;
  logic        y_vld8;
  logic [3:0]  y8;

  int checks;
  int errors;
  int cnt;

  logic        hv32 [HN];
  logic [15:0] hy32 [HN];
  logic        hv8  [HN];
  logic [15:0] hy8  [HN];

  isqrt_pipe #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .x_vld (x_vld32),
    .x     (x32),
    .y_vld (y_vld32),
    .y     (y32)
  );

  isqrt_pipe #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .x_vld (x_vld8),
    .x     (x8),
    .y_vld (y_vld8),
    .y     (y8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference root by bitwise search using multiplication.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, v}) r = t;
    end
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: at the falling edge check the outputs against the
  // operands driven D cycles earlier, then drive this cycle's operands.
  task automatic tick(input logic v32, input logic [31:0] xi32, input logic [15:0] e32,
                      input logic v8, input logic [7:0] xi8, input logic [15:0] e8);
    @(negedge clk);
    chk("y_vld32", {31'd0, y_vld32}, {31'd0, hv32[cnt-D32]});
    if (hv32[cnt-D32]) chk("y32", {16'd0, y32}, {16'd0, hy32[cnt-D32]});
    chk("y_vld8", {31'd0, y_vld8}, {31'd0, hv8[cnt-D8]});
    if (hv8[cnt-D8]) chk("y8", {28'd0, y8}, {16'd0, hy8[cnt-D8]});
    x_vld32 = v32;
    x32     = xi32;
    x_vld8  = v8;
    x8      = xi8;
    hv32[cnt] = v32 & rst_n;
    hy32[cnt] = e32;
    hv8[cnt]  = v8 & rst_n;
    hy8[cnt]  = e8;
    cnt++;
  endtask

  task automatic idle();
    tick(1'b0, $urandom, 16'd0, 1'b0, 8'($urandom), 16'd0);
  endtask

  task automatic wipe_history();
    for (int i = 0; i < int'(HN); i++) begin
      hv32[i] = 1'b0;
      hv8[i]  = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] xr;
    logic        vr;
    checks  = 0;
    errors  = 0;
    cnt     = D32;
    rst_n   = 1'b0;
    x_vld32 = 1'b0;
    x32     = '0;
    x_vld8  = 1'b0;
    x8      = '0;
    wipe_history();

    // Reset state
    #1;
    chk("rst_y_vld32", {31'd0, y_vld32}, 32'd0);
    chk("rst_y_vld8", {31'd0, y_vld8}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Corners with hand-computed roots, back-to-back from the first edge
    tick(1'b1, 32'h0000_0000, 16'h0000, 1'b1, 8'd0,   16'd0);
    tick(1'b1, 32'h0000_0001, 16'h0001, 1'b1, 8'd1,   16'd1);
    tick(1'b1, 32'h0000_000F, 16'h0003, 1'b1, 8'd15,  16'd3);
    tick(1'b1, 32'h0000_0010, 16'h0004, 1'b1, 8'd16,  16'd4);
    tick(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 8'd255, 16'd15);
    tick(1'b1, 32'hFFFE_0001, 16'hFFFF, 1'b1, 8'd225, 16'd15);
    tick(1'b1, 32'hFFFE_0000, 16'hFFFE, 1'b1, 8'd224, 16'd14);
    tick(1'b1, 32'd99,        16'd9,    1'b0, 8'd0,   16'd0);
    tick(1'b1, 32'h0001_0000, 16'h0100, 1'b1, 8'd63,  16'd7);
    tick(1'b1, 32'h3FFF_FFFF, 16'h7FFF, 1'b1, 8'd64,  16'd8);
    tick(1'b0, 32'd0,         16'd0,    1'b0, 8'd0,   16'd0);
    tick(1'b1, 32'h4000_0000, 16'h8000, 1'b1, 8'd3,   16'd1);
    for (int i = 0; i < 16; i++) idle();

    // Streaming 1000 random operands; WIDTH=8 exhaustive sweep alongside
    for (int i = 0; i < 1000; i++) begin
      xr = $urandom;
      if (i < 256) tick(1'b1, xr, ref_sqrt(xr), 1'b1, 8'(i), ref_sqrt(32'(i)));
      else         tick(1'b1, xr, ref_sqrt(xr), 1'b0, 8'd0, 16'd0);
    end

    // Reset mid-stream: five more accepted, then reset between edges
    for (int i = 0; i < 5; i++) begin
      xr = $urandom;
      tick(1'b1, xr, ref_sqrt(xr), 1'b0, 8'd0, 16'd0);
    end
    #6;
    chk("pre_rst_y_vld32", {31'd0, y_vld32}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_y_vld32", {31'd0, y_vld32}, 32'd0);
    chk("async_rst_y_vld8", {31'd0, y_vld8}, 32'd0);
    wipe_history();
    for (int i = 0; i < 3; i++) begin
      xr = $urandom;
      tick(1'b1, xr, ref_sqrt(xr), 1'b1, 8'(xr), 16'd0);
    end
    #7 rst_n = 1'b1;
    tick(1'b1, 32'd144, 16'd12, 1'b1, 8'd144, 16'd12);
    for (int i = 0; i < 20; i++) idle();

    // Bubbles: random 50% valid pattern
    for (int i = 0; i < 200; i++) begin
      xr = $urandom;
      vr = 1'($urandom_range(0, 1));
      tick(vr, xr, ref_sqrt(xr), ~vr, 8'(xr), ref_sqrt({24'd0, xr[7:0]}));
    end
    for (int i = 0; i < 16; i++) idle();

    // Power gating: one operand, then 40 idle cycles with x toggling
    tick(1'b1, 32'h0009_0000, 16'h0300, 1'b0, 8'd0, 16'd0);
    for (int k = 1; k <= 40; k++) begin
      idle();
      chk("gate_stage0_opd", dut32.opd_q[0], 32'h0024_0000);
      if (k >= 16) chk("gate_y32", {16'd0, y32}, 32'h0000_0300);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
